// File: rtl/display_source_arbiter.sv
// rtl/display_source_arbiter.sv - round-robin time-sharing of the seven-segment display between BCD sources
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   src_req    level request per source (bit i = source i)
//   src_bcd    packed 16-bit BCD words, source i at [16*i+15:16*i]
//   grant      one-hot grant, all-zero when idle or in the blank gap
//   bcd_out    BCD word forwarded to the segment driver
//   busy       high while showing a source or blanking between sources
//   dwell_done one-cycle pulse when a grant completes its full dwell
module display_source_arbiter #(
    parameter int          NUM_SRC      = 3,
    parameter int          DWELL_CYCLES = 100000000,
    parameter int          GAP_CYCLES   = 10000000,
    parameter logic [15:0] IDLE_BCD     = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [16*NUM_SRC-1:0]   src_bcd,
    output logic [NUM_SRC-1:0]      grant,
    output logic [15:0]             bcd_out,
    output logic                    busy,
    output logic                    dwell_done
);

    localparam int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int MAX_CNT = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PW-1:0] LAST_SRC   = PW'(NUM_SRC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]         state, nxt_state;
    logic [CW-1:0]      cnt, nxt_cnt;
    logic [PW-1:0]      last_ptr, nxt_ptr;
    logic               nxt_dwell;
    logic [NUM_SRC-1:0] pick_mask;
    logic               pick_any;
    logic [PW-1:0]      pick_idx;
    logic [NUM_SRC-1:0] nxt_grant;
    logic [15:0]        bcd_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign bcd_arr[i] = src_bcd[16*i +: 16];
    end

    // First requester scanning ptr+1, ptr+2, ... modulo NUM_SRC.
    // Scanning backwards lets the nearest hit overwrite farther ones.
    function automatic logic [PW:0] rr_pick(input logic [NUM_SRC-1:0] mask,
                                            input logic [PW-1:0]      ptr);
        logic [PW:0] r;
        logic [PW:0] s;
        r = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            s = {1'b0, ptr} + (PW+1)'(k);
            if (s >= (PW+1)'(NUM_SRC)) begin
                s = s - (PW+1)'(NUM_SRC);
            end
            if (mask[s[PW-1:0]]) begin
                r = {1'b1, s[PW-1:0]};
            end
        end
        return r;
    endfunction

    // While showing, last_ptr is the current owner; the pick then only
    // considers the other sources, which decides rotate-vs-stay.
    always_comb begin
        pick_mask             = (state == ST_SHOW) ? (src_req & ~grant) : src_req;
        {pick_any, pick_idx}  = rr_pick(pick_mask, last_ptr);
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_ptr   = last_ptr;
        nxt_dwell = 1'b0;
        case (state)
            ST_IDLE: begin
                nxt_cnt = '0;
                if (pick_any) begin
                    nxt_state = ST_SHOW;
                    nxt_ptr   = pick_idx;
                end
            end
            ST_SHOW: begin
                // Dwell pulse fires even if the request drops on the same edge.
                nxt_dwell = (cnt == DWELL_LAST);
                if (!src_req[last_ptr] || (cnt == DWELL_LAST)) begin
                    nxt_cnt = '0;
                    if (pick_any) begin
                        if (GAP_CYCLES > 0) begin
                            nxt_state = ST_GAP;
                        end else begin
                            nxt_ptr = pick_idx;
                        end
                    end else if (!src_req[last_ptr]) begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    nxt_cnt = '0;
                    if (pick_any) begin
                        nxt_state = ST_SHOW;
                        nxt_ptr   = pick_idx;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    assign nxt_grant = (nxt_state == ST_SHOW) ? (NUM_SRC'(1) << nxt_ptr) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_ptr   <= LAST_SRC;
            grant      <= '0;
            bcd_out    <= IDLE_BCD;
            busy       <= 1'b0;
            dwell_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            last_ptr   <= nxt_ptr;
            grant      <= nxt_grant;
            busy       <= (nxt_state != ST_IDLE);
            dwell_done <= nxt_dwell;
            // Data trails the grant by one register stage; blank whenever
            // the display is entering or leaving a blank period.
            bcd_out    <= ((state == ST_SHOW) && (nxt_state == ST_SHOW)) ? bcd_arr[last_ptr] : IDLE_BCD;
        end
    end

endmodule
